// File: rtl/pbl_prof_pkg.sv
// Shared definitions for the profile interface blocks: FSM states and the
// profile range check.
package pbl_prof_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // A code is legal when 1 <= code <= max_code. Callers zero-extend to 32 bits.
  function automatic logic prof_legal(input logic [31:0] code,
                                      input logic [31:0] max_code);
    return (code != 32'd0) && (code <= max_code);
  endfunction

endpackage

// File: rtl/profile_transfer_arbiter_rr_grant.sv
// Combinational round-robin picker: the first requester at or after ptr,
// wrapping modulo N_IF.
module rr_grant #(
  parameter  int N_IF  = 2,
  localparam int SRC_W = $clog2(N_IF)
) (
  input  logic [N_IF-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_IF-1:0]  grant_oh,
  output logic [SRC_W-1:0] grant_idx,
  output logic             any
);

  logic [SRC_W-1:0] sel;

  // Scan N_IF slots starting at ptr; the first set request wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    sel       = '0;
    for (int k = 0; k < N_IF; k++) begin
      sel = SRC_W'((int'(ptr) + k) % N_IF);
      if (!any && req[sel]) begin
        any           = 1'b1;
        grant_oh[sel] = 1'b1;
        grant_idx     = sel;
      end
    end
  end

endmodule

// File: rtl/profile_transfer_arbiter.sv
// Round-robin arbiter forwarding range-checked profile codes from N_IF
// requesters onto one registered valid/ready output. Illegal codes are
// consumed and reported on err_pulse/err_src instead of being forwarded.
//
// state | meaning
// IDLE  | no profile held; grant one requester per cycle
// SEND  | profile held on out_*; waiting for out_ready
module profile_transfer_arbiter
  import pbl_prof_pkg::*;
#(
  parameter  int N_IF     = 2,
  parameter  int PROF_W   = 3,
  parameter  int MAX_PROF = 6,
  localparam int SRC_W    = $clog2(N_IF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IF-1:0]        if_valid,
  input  logic [N_IF*PROF_W-1:0] if_prof,
  output logic [N_IF-1:0]        if_ready,
  output logic                   out_valid,
  output logic [PROF_W-1:0]      out_prof,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_ready,
  output logic                   err_pulse,
  output logic [SRC_W-1:0]       err_src
);

  localparam logic [0:0]       ST_IDLE  = IDLE;
  localparam logic [0:0]       ST_SEND  = SEND;
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_IF - 1);

  logic [0:0]        state_q, state_d;
  logic [SRC_W-1:0]  rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [PROF_W-1:0] out_prof_q, out_prof_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;
  logic              err_pulse_q, err_pulse_d;
  logic [SRC_W-1:0]  err_src_q, err_src_d;

  logic [N_IF-1:0]   grant_oh;
  logic [SRC_W-1:0]  grant_idx;
  logic              grant_any;
  logic [PROF_W-1:0] grant_prof;
  logic              grant_legal;

  rr_grant #(.N_IF(N_IF)) u_rr_grant (
    .req       (if_valid),
    .ptr       (rr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Select the granted requester's profile code.
  always_comb begin
    grant_prof = '0;
    for (int i = 0; i < N_IF; i++) begin
      if (grant_oh[i]) grant_prof = if_prof[i*PROF_W +: PROF_W];
    end
  end

  assign grant_legal = prof_legal(32'(grant_prof), 32'(MAX_PROF));

  // Accept pulses exist only in IDLE and never while reset is asserted, so a
  // requester is never told it was consumed by a cycle that reset discards.
  assign if_ready = (rst_n && state_q == ST_IDLE) ? grant_oh : '0;

  // Next-state: grant in IDLE (forward or flag), drain on out_ready in SEND.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_prof_d  = out_prof_q;
    out_src_d   = out_src_q;
    err_pulse_d = 1'b0;
    err_src_d   = err_src_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          rr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          if (grant_legal) begin
            out_valid_d = 1'b1;
            out_prof_d  = grant_prof;
            out_src_d   = grant_idx;
            state_d     = ST_SEND;
          end else begin
            err_pulse_d = 1'b1;
            err_src_d   = grant_idx;
          end
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_prof_d  = '0;
          out_src_d   = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_prof_d  = '0;
        out_src_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_prof_q  <= '0;
      out_src_q   <= '0;
      err_pulse_q <= 1'b0;
      err_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_prof_q  <= out_prof_d;
      out_src_q   <= out_src_d;
      err_pulse_q <= err_pulse_d;
      err_src_q   <= err_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_prof  = out_prof_q;
  assign out_src   = out_src_q;
  assign err_pulse = err_pulse_q;
  assign err_src   = err_src_q;

endmodule
